mem_load_unit: RTL and testbench

Load path front end of the multicycle CPU. It owns the data-memory read handshake for load instructions and extracts the addressed byte or halfword. It sign- or zero-extends the result and holds it in the memory data register, `Mem_D_out`. The write-back data select consumes `Mem_D_out` when `MemToReg` is 1. The control unit pulses `start` in the MEM state and waits for `done` before advancing to write-back.

---
 rtl/mem_load_if.sv | 23 ++
 rtl/mem_load_unit.sv | 103 ++++++++++
 tb/tb_mem_load_unit.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mem_load_if.sv
// mem_load_if: load request, data-memory read handshake and result bus of the load unit
interface mem_load_if;
    logic        start;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        unsigned_ld;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [31:0] Mem_D_out;
    logic        busy;
    logic        done;
    logic        err;
    modport master (
        output start, addr, size, unsigned_ld, mem_rdata, mem_ready,
        input  mem_rd_en, mem_addr, Mem_D_out, busy, done, err
    );
    modport slave (
        input  start, addr, size, unsigned_ld, mem_rdata, mem_ready,
        output mem_rd_en, mem_addr, Mem_D_out, busy, done, err
    );
endinterface

// File: rtl/mem_load_unit.sv
// mem_load_unit: data-memory load handshake with byte/halfword extraction into Mem_D_out; LOAD_ALIGN_CHECK_EN enables misalignment errors
module mem_load_unit #(
    parameter int TIMEOUT = 15
) (
    input  logic     clk,
    input  logic     rst_n,
    mem_load_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] dout_q, dout_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        rd_en_q, rd_en_d;
    logic        err_q, err_d;
    logic        mis;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] ext;

`ifdef LOAD_ALIGN_CHECK_EN
    assign mis = (bus.size == 2'b01 && bus.addr[0]) || (bus.size[1] && bus.addr[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif

    // pick the addressed lane and extend it to 32 bits
    always_comb begin
        lane_b = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        lane_h = bus.mem_rdata[{addr_q[1], 4'b0000} +: 16];
        ext    = size_q[1] ? bus.mem_rdata :
                 size_q[0] ? {{16{lane_h[15] & ~uns_q}}, lane_h} :
                             {{24{lane_b[7] & ~uns_q}}, lane_b};
    end

    // next-state and datapath updates of the IDLE/WAIT/DONE controller
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        size_d  = size_q;
        uns_d   = uns_q;
        rd_en_d = rd_en_q;
        err_d   = err_q;
        dout_d  = dout_q;
        case (state_q)
            IDLE: if (bus.start) begin
                addr_d  = bus.addr;
                size_d  = bus.size;
                uns_d   = bus.unsigned_ld;
                cnt_d   = '0;
                err_d   = mis;
                rd_en_d = ~mis;
                state_d = mis ? DONE : WAIT;
            end
            WAIT: if (bus.mem_ready) begin
                dout_d  = ext;
                rd_en_d = 1'b0;
                state_d = DONE;
            end else if (cnt_q == LAST) begin
                rd_en_d = 1'b0;
                err_d   = 1'b1;
                state_d = DONE;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            rd_en_q <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            rd_en_q <= rd_en_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
        end
    end

    assign bus.mem_rd_en = rd_en_q;
    assign bus.mem_addr  = {addr_q[31:2], 2'b00};
    assign bus.Mem_D_out = dout_q;
    assign bus.busy      = state_q != IDLE;
    assign bus.done      = state_q == DONE;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_mem_load_unit.sv
// tb_mem_load_unit: directed load vectors plus reset and ignored-start sequences for mem_load_unit (TIMEOUT=4)
module tb_mem_load_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int tests = 0;
    int fails = 0;

    mem_load_if bus ();
    mem_load_unit #(.TIMEOUT(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] rdata;
        int          k;
        logic [31:0] exp_dout;
        logic        exp_err;
        int          exp_lat;
        int          exp_rd;
        logic [31:0] exp_maddr;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat = 99;
        int rd = 0;
        logic [31:0] maddr = '0;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.addr = v.addr;
        bus.size = v.size;
        bus.unsigned_ld = v.uns;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (bus.done) begin
                lat = n;
                break;
            end
            bus.mem_ready = (n + 1 == v.k);
            bus.mem_rdata = (n + 1 == v.k) ? v.rdata : ~v.rdata;
            if (bus.mem_rd_en) begin
                rd++;
                maddr = bus.mem_addr;
            end
            @(posedge clk); #1;
            bus.mem_ready = 1'b0;
        end
        chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.exp_lat));
        chk($sformatf("v%0d rd_en cycles", idx), 32'(rd), 32'(v.exp_rd));
        chk($sformatf("v%0d Mem_D_out", idx), bus.Mem_D_out, v.exp_dout);
        chk($sformatf("v%0d err", idx), 32'(bus.err), 32'(v.exp_err));
        if (v.exp_rd > 0) chk($sformatf("v%0d mem_addr", idx), maddr, v.exp_maddr);
        @(posedge clk); #1;
        chk($sformatf("v%0d done pulse width", idx), 32'(bus.done), 32'd0);
        chk($sformatf("v%0d busy after", idx), 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int dones;
        bus.start = 1'b0;
        bus.addr = '0;
        bus.size = '0;
        bus.unsigned_ld = 1'b0;
        bus.mem_rdata = '0;
        bus.mem_ready = 1'b0;
        vecs[0]  = '{32'h100, 2'b10, 1'b0, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1'b0, 1, 1, 32'h100};
        vecs[1]  = '{32'h300, 2'b00, 1'b0, 32'h80FF7F01, 1, 32'h00000001, 1'b0, 1, 1, 32'h300};
        vecs[2]  = '{32'h301, 2'b00, 1'b0, 32'h80FF7F01, 2, 32'h0000007F, 1'b0, 2, 2, 32'h300};
        vecs[3]  = '{32'h302, 2'b00, 1'b0, 32'h80FF7F01, 1, 32'hFFFFFFFF, 1'b0, 1, 1, 32'h300};
        vecs[4]  = '{32'h303, 2'b00, 1'b0, 32'h80FF7F01, 3, 32'hFFFFFF80, 1'b0, 3, 3, 32'h300};
        vecs[5]  = '{32'h303, 2'b00, 1'b1, 32'h80FF7F01, 1, 32'h00000080, 1'b0, 1, 1, 32'h300};
        vecs[6]  = '{32'h202, 2'b01, 1'b0, 32'h80017FFE, 1, 32'hFFFF8001, 1'b0, 1, 1, 32'h200};
        vecs[7]  = '{32'h200, 2'b01, 1'b1, 32'h80017FFE, 2, 32'h00007FFE, 1'b0, 2, 2, 32'h200};
        vecs[8]  = '{32'h400, 2'b11, 1'b0, 32'h55555555, 0, 32'h00007FFE, 1'b1, 4, 4, 32'h400};
        vecs[9]  = '{32'h404, 2'b10, 1'b0, 32'h12345678, 4, 32'h12345678, 1'b0, 4, 4, 32'h404};
`ifdef LOAD_ALIGN_CHECK_EN
        vecs[10] = '{32'h102, 2'b10, 1'b0, 32'hCAFEF00D, 1, 32'h12345678, 1'b1, 0, 0, 32'h100};
        vecs[11] = '{32'h201, 2'b01, 1'b0, 32'h12348765, 1, 32'h12345678, 1'b1, 0, 0, 32'h200};
`else
        vecs[10] = '{32'h102, 2'b10, 1'b0, 32'hCAFEF00D, 1, 32'hCAFEF00D, 1'b0, 1, 1, 32'h100};
        vecs[11] = '{32'h201, 2'b01, 1'b0, 32'h12348765, 1, 32'hFFFF8765, 1'b0, 1, 1, 32'h200};
`endif
        #2 rst_n = 1'b0;
        #1;
        chk("reset mem_rd_en", 32'(bus.mem_rd_en), 32'd0);
        chk("reset mem_addr", bus.mem_addr, 32'd0);
        chk("reset Mem_D_out", bus.Mem_D_out, 32'd0);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset err", 32'(bus.err), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.addr = 32'h600;
        bus.size = 2'b10;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        chk("midwait rd_en before reset", 32'(bus.mem_rd_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async reset rd_en", 32'(bus.mem_rd_en), 32'd0);
        chk("async reset busy", 32'(bus.busy), 32'd0);
        chk("async reset mem_addr", bus.mem_addr, 32'd0);
        chk("async reset Mem_D_out", bus.Mem_D_out, 32'd0);
        chk("async reset err", 32'(bus.err), 32'd0);
        dones = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        chk("no done during reset", 32'(dones), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            bus.start = (i == 0 || i == 1 || i == 2 || i == 4);
            bus.addr = (i == 0) ? 32'h700 : 32'h800;
            bus.mem_ready = (i == 3);
            bus.mem_rdata = 32'h11223344;
            @(posedge clk); #1;
            bus.start = 1'b0;
            bus.mem_ready = 1'b0;
            if (bus.done) dones++;
        end
        chk("ignored start done count", 32'(dones), 32'd1);
        chk("ignored start mem_addr", bus.mem_addr, 32'h700);
        chk("ignored start Mem_D_out", bus.Mem_D_out, 32'h11223344);
        chk("ignored start busy", 32'(bus.busy), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
